// File: rtl/p2c_sequencer.sv
// Polar->cartesian pass sequencer: sweeps one mag/phase buffer pair through a
// fixed-latency CORDIC rotator into the pre-IFFT buffers, then pulses go_out.
module p2c_sequencer #(
  parameter int unsigned N_POINTS   = 4096,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned CORDIC_LAT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go_in,
  input  logic              cur_window,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mag_buf_0_data,
  input  logic [DATA_W-1:0] phase_buf_0_data,
  input  logic [DATA_W-1:0] mag_buf_1_data,
  input  logic [DATA_W-1:0] phase_buf_1_data,
  output logic              cordic_in_valid,
  output logic [DATA_W-1:0] cordic_mag,
  output logic [DATA_W-1:0] cordic_phase,
  input  logic [DATA_W-1:0] cordic_re,
  input  logic [DATA_W-1:0] cordic_im,
  output logic [DATA_W-1:0] real_buf_data,
  output logic [DATA_W-1:0] imag_buf_data,
  output logic [ADDR_W-1:0] real_buf_addr,
  output logic [ADDR_W-1:0] imag_buf_addr,
  output logic              real_buf_wren,
  output logic              imag_buf_wren,
  output logic              go_out,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned PIPE_LAT = RD_LAT + CORDIC_LAT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                go_out_q, go_out_d;
  logic                rd_issue_q, rd_issue_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;
  logic [CORDIC_LAT-1:0] wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0]   addr_pipe_q [PIPE_LAT];
  logic [ADDR_W-1:0]   addr_pipe_d [PIPE_LAT];

  // Valid and address delay lines: read issue -> rotator input -> buffer write.
  always_comb begin
    rd_vld_d = (rd_vld_q << 1) | RD_LAT'(rd_issue_q);
    wr_vld_d = (wr_vld_q << 1) | CORDIC_LAT'(rd_vld_q[RD_LAT-1]);
    addr_pipe_d[0] = rd_addr_q;
    for (int i = 1; i < int'(PIPE_LAT); i++) begin
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end
  end

  // Pass sequencing: accept, sweep addresses, wait for the pipeline to empty, pulse done.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;
    go_out_d   = 1'b0;
    rd_issue_d = 1'b0;
    rd_addr_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (go_in) begin
          state_d    = S_SWEEP;
          win_d      = cur_window;
          busy_d     = 1'b1;
          overrun_d  = 1'b0;
          rd_issue_d = 1'b1;
        end
      end
      S_SWEEP: begin
        if (go_in) overrun_d = 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          rd_issue_d = 1'b1;
          rd_addr_d  = rd_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (go_in) overrun_d = 1'b1;
        // The write landing this cycle is the last one once nothing remains behind it.
        if ((rd_vld_d == '0) && (wr_vld_d == '0)) begin
          state_d  = S_DONE;
          go_out_d = 1'b1;
        end
      end
      S_DONE: begin
        if (go_in) overrun_d = 1'b1;
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      win_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      go_out_q   <= 1'b0;
      rd_issue_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_vld_q   <= '0;
      wr_vld_q   <= '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        addr_pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      go_out_q    <= go_out_d;
      rd_issue_q  <= rd_issue_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      wr_vld_q    <= wr_vld_d;
      addr_pipe_q <= addr_pipe_d;
    end
  end

  // Data muxing is combinational; words are zeroed outside their valid cycles.
  assign rd_addr         = rd_addr_q;
  assign cordic_in_valid = rd_vld_q[RD_LAT-1];
  assign cordic_mag      = cordic_in_valid ? (win_q ? mag_buf_1_data : mag_buf_0_data) : '0;
  assign cordic_phase    = cordic_in_valid ? (win_q ? phase_buf_1_data : phase_buf_0_data) : '0;
  assign real_buf_wren   = wr_vld_q[CORDIC_LAT-1];
  assign imag_buf_wren   = wr_vld_q[CORDIC_LAT-1];
  assign real_buf_addr   = addr_pipe_q[PIPE_LAT-1];
  assign imag_buf_addr   = addr_pipe_q[PIPE_LAT-1];
  assign real_buf_data   = real_buf_wren ? cordic_re : '0;
  assign imag_buf_data   = imag_buf_wren ? cordic_im : '0;
  assign go_out          = go_out_q;
  assign busy            = busy_q;
  assign overrun         = overrun_q;

endmodule
